// File: rtl/kronos_types.sv
// Kronos shared types: EX->WB bundle, data-size and trap-cause codes, WB state.
package kronos_types;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] WORD = 2'd2;

  localparam logic [3:0] ILLEGAL     = 4'd2;
  localparam logic [3:0] LD_MISALIGN = 4'd4;
  localparam logic [3:0] ST_MISALIGN = 4'd6;

  typedef enum logic {
    STEADY = 1'b0,
    MEM    = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [XLEN-1:0] result1;
    logic [XLEN-1:0] result2;
    logic [REGW-1:0] rd;
    logic            rd_write;
    logic            branch;
    logic            branch_cond;
    logic            ld;
    logic            st;
    logic [1:0]      data_size;
    logic            data_uns;
    logic            is_illegal;
  } pipeEXWB_t;

endpackage

// File: rtl/kronos_lsu_align.sv
// Byte-lane alignment: store shift/mask and load extract with sign/zero extension.
module kronos_lsu_align
  import kronos_types::*;
(
  input  logic [1:0]      i_st_addr_lo,
  input  logic [1:0]      i_st_size,
  input  logic [XLEN-1:0] i_st_data,
  input  logic [1:0]      i_ld_addr_lo,
  input  logic [1:0]      i_ld_size,
  input  logic            i_ld_uns,
  input  logic [XLEN-1:0] i_ld_data,
  output logic [3:0]      o_st_mask,
  output logic [XLEN-1:0] o_st_data,
  output logic [XLEN-1:0] o_ld_data
);

  logic [XLEN-1:0] w_ld_shift;

  // Store lanes: shift data into position, lanes pushed past byte 3 are dropped
  always_comb begin
    o_st_data = i_st_data << {i_st_addr_lo, 3'b000};
    case (i_st_size)
      BYTE:    o_st_mask = 4'(4'b0001 << i_st_addr_lo);
      HALF:    o_st_mask = 4'(4'b0011 << i_st_addr_lo);
      default: o_st_mask = 4'hF;
    endcase
  end

  // Load extract: right-align the addressed lanes, then truncate and extend
  always_comb begin
    w_ld_shift = i_ld_data >> {i_ld_addr_lo, 3'b000};
    case (i_ld_size)
      BYTE:    o_ld_data = i_ld_uns ? {24'b0, w_ld_shift[7:0]}
                                    : {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      HALF:    o_ld_data = i_ld_uns ? {16'b0, w_ld_shift[15:0]}
                                    : {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      default: o_ld_data = w_ld_shift;
    endcase
  end

endmodule

// File: rtl/kronos_writeback.sv
// Kronos RV32I write-back stage: register commit, branch redirect, load/store, traps.
// Optional: define KRONOS_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module kronos_writeback
  import kronos_types::*;
(
  input  logic            clk,
  input  logic            rstz,
  input  pipeEXWB_t       execute,
  input  logic            pipe_in_vld,
  output logic            pipe_in_rdy,
  output logic [XLEN-1:0] regwr_data,
  output logic [REGW-1:0] regwr_sel,
  output logic            regwr_en,
  output logic            branch,
  output logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] data_addr,
  output logic            data_req,
  output logic            data_wr_en,
  output logic [3:0]      data_mask,
  output logic [XLEN-1:0] data_wr_data,
  input  logic [XLEN-1:0] data_rd_data,
  input  logic            data_ack,
  output logic            trap_vld,
  output logic [3:0]      trap_cause,
  output logic [XLEN-1:0] trap_value
);

  wb_state_e       r_state;
  wb_state_e       w_state_nxt;
  logic            w_accept;
  logic            w_is_mem;
  logic            w_misalign;
  logic            w_mem_go;
  logic            w_taken;
  logic [1:0]      r_addr_lo;
  logic [1:0]      r_size;
  logic            r_uns;
  logic            r_ld_wr;
  logic [REGW-1:0] r_rd;
  logic [3:0]      w_st_mask;
  logic [XLEN-1:0] w_st_data;
  logic [XLEN-1:0] w_ld_data;

  assign pipe_in_rdy = (r_state == STEADY);
  assign w_accept    = pipe_in_vld && pipe_in_rdy;
  assign w_is_mem    = execute.ld || execute.st;
  assign w_taken     = execute.branch || (execute.branch_cond && execute.result1[0]);

`ifdef KRONOS_MISALIGN_TRAP_EN
  assign w_misalign = (execute.data_size == HALF) ? execute.result1[0]
                    : (execute.data_size != BYTE) && (|execute.result1[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_mem_go = w_accept && w_is_mem && !execute.is_illegal && !w_misalign;

  kronos_lsu_align u_align (
    .i_st_addr_lo (execute.result1[1:0]),
    .i_st_size    (execute.data_size),
    .i_st_data    (execute.result2),
    .i_ld_addr_lo (r_addr_lo),
    .i_ld_size    (r_size),
    .i_ld_uns     (r_uns),
    .i_ld_data    (data_rd_data),
    .o_st_mask    (w_st_mask),
    .o_st_data    (w_st_data),
    .o_ld_data    (w_ld_data)
  );

  // State register
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) r_state <= STEADY;
    else       r_state <= w_state_nxt;
  end

  // Next state: enter MEM on a clean ld/st accept, leave on bus ack
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      STEADY:  if (w_mem_go) w_state_nxt = MEM;
      MEM:     if (data_ack) w_state_nxt = STEADY;
      default: w_state_nxt = STEADY;
    endcase
  end

  // Registered outputs: single-cycle strobes, held bus request, load context
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      regwr_en      <= 1'b0;
      regwr_data    <= '0;
      regwr_sel     <= '0;
      branch        <= 1'b0;
      branch_target <= '0;
      data_req      <= 1'b0;
      data_wr_en    <= 1'b0;
      data_addr     <= '0;
      data_mask     <= '0;
      data_wr_data  <= '0;
      trap_vld      <= 1'b0;
      trap_cause    <= '0;
      trap_value    <= '0;
      r_addr_lo     <= '0;
      r_size        <= '0;
      r_uns         <= 1'b0;
      r_ld_wr       <= 1'b0;
      r_rd          <= '0;
    end else begin
      regwr_en <= 1'b0;
      branch   <= 1'b0;
      trap_vld <= 1'b0;
      if (w_accept) begin
        if (execute.is_illegal) begin
          trap_vld   <= 1'b1;
          trap_cause <= ILLEGAL;
          trap_value <= '0;
        end else if (w_is_mem && w_misalign) begin
          trap_vld   <= 1'b1;
          trap_cause <= execute.ld ? LD_MISALIGN : ST_MISALIGN;
          trap_value <= execute.result1;
        end else if (w_is_mem) begin
          data_req     <= 1'b1;
          data_wr_en   <= execute.st;
          data_addr    <= {execute.result1[XLEN-1:2], 2'b00};
          data_mask    <= w_st_mask;
          data_wr_data <= w_st_data;
          r_addr_lo    <= execute.result1[1:0];
          r_size       <= execute.data_size;
          r_uns        <= execute.data_uns;
          r_ld_wr      <= execute.ld && execute.rd_write && (execute.rd != '0);
          r_rd         <= execute.rd;
        end else begin
          regwr_en      <= execute.rd_write && (execute.rd != '0) && !execute.branch_cond;
          regwr_data    <= execute.result1;
          regwr_sel     <= execute.rd;
          branch        <= w_taken;
          branch_target <= execute.result2;
        end
      end else if ((r_state == MEM) && data_ack) begin
        data_req   <= 1'b0;
        data_wr_en <= 1'b0;
        regwr_en   <= r_ld_wr;
        regwr_data <= w_ld_data;
        regwr_sel  <= r_rd;
      end
    end
  end

endmodule

// File: tb/tb_kronos_writeback.sv
// Self-checking bench for kronos_writeback: strobe scoreboard plus directed bus checks.
module tb_kronos_writeback;
  import kronos_types::*;

  logic        clk = 1'b0;
  logic        rstz;
  pipeEXWB_t   execute;
  logic        pipe_in_vld;
  logic        pipe_in_rdy;
  logic [31:0] regwr_data;
  logic [4:0]  regwr_sel;
  logic        regwr_en;
  logic        branch;
  logic [31:0] branch_target;
  logic [31:0] data_addr;
  logic        data_req;
  logic        data_wr_en;
  logic [3:0]  data_mask;
  logic [31:0] data_wr_data;
  logic [31:0] data_rd_data;
  logic        data_ack;
  logic        trap_vld;
  logic [3:0]  trap_cause;
  logic [31:0] trap_value;

  kronos_writeback dut (
    .clk           (clk),
    .rstz          (rstz),
    .execute       (execute),
    .pipe_in_vld   (pipe_in_vld),
    .pipe_in_rdy   (pipe_in_rdy),
    .regwr_data    (regwr_data),
    .regwr_sel     (regwr_sel),
    .regwr_en      (regwr_en),
    .branch        (branch),
    .branch_target (branch_target),
    .data_addr     (data_addr),
    .data_req      (data_req),
    .data_wr_en    (data_wr_en),
    .data_mask     (data_mask),
    .data_wr_data  (data_wr_data),
    .data_rd_data  (data_rd_data),
    .data_ack      (data_ack),
    .trap_vld      (trap_vld),
    .trap_cause    (trap_cause),
    .trap_value    (trap_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  strb;   // {regwr_en, branch, trap_vld}
    logic [31:0] rdata;
    logic [4:0]  sel;
    logic [31:0] tgt;
    logic [3:0]  cause;
    logic [31:0] tval;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [2:0] strb, input logic [4:0] sel,
                                  input logic [31:0] rdata, input logic [31:0] tgt,
                                  input logic [3:0] cause, input logic [31:0] tval);
    exp_t e;
    e.strb = strb; e.sel = sel; e.rdata = rdata; e.tgt = tgt; e.cause = cause; e.tval = tval;
    return e;
  endfunction

  function automatic pipeEXWB_t mk_alu(input logic [4:0] rd, input logic [31:0] r1);
    pipeEXWB_t b = '0;
    b.rd = rd; b.rd_write = 1'b1; b.result1 = r1;
    return b;
  endfunction

  function automatic pipeEXWB_t mk_mem(input logic ld, input logic [1:0] size, input logic uns,
                                       input logic [4:0] rd, input logic [31:0] addr,
                                       input logic [31:0] sdata);
    pipeEXWB_t b = '0;
    b.ld = ld; b.st = !ld; b.data_size = size; b.data_uns = uns;
    b.rd = rd; b.rd_write = ld; b.result1 = addr; b.result2 = sdata;
    return b;
  endfunction

  // Strobe monitor: every strobe cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (rstz && (regwr_en || branch || trap_vld)) begin
      if (sb.size() == 0) begin
        chk("spurious_strobe", 32'({regwr_en, branch, trap_vld}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobes", 32'({regwr_en, branch, trap_vld}), 32'(e.strb));
        if (e.strb[2]) begin
          chk("regwr_sel", 32'(regwr_sel), 32'(e.sel));
          chk("regwr_data", regwr_data, e.rdata);
        end
        if (e.strb[1]) chk("branch_target", branch_target, e.tgt);
        if (e.strb[0]) begin
          chk("trap_cause", 32'(trap_cause), 32'(e.cause));
          chk("trap_value", trap_value, e.tval);
        end
      end
    end
  end

  // Present one bundle for one cycle; caller is at posedge+1
  task automatic issue(input pipeEXWB_t b);
    execute = b;
    pipe_in_vld = 1'b1;
    @(posedge clk); #1;
    pipe_in_vld = 1'b0;
    execute = '0;
  endtask

  // Issue a load/store, hold the bus for `waits` cycles, then ack
  task automatic mem_op(input pipeEXWB_t b, input int waits, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                        input logic [31:0] exp_wdata);
    issue(b);
    for (int w = 0; w <= waits; w++) begin
      chk("data_req_held", 32'(data_req), 32'd1);
      chk("data_addr", data_addr, exp_addr);
      chk("data_mask", 32'(data_mask), 32'(exp_mask));
      chk("data_wr_en", 32'(data_wr_en), 32'(b.st));
      if (b.st) chk("data_wr_data", data_wr_data, exp_wdata);
      chk("rdy_in_mem", 32'(pipe_in_rdy), 32'd0);
      if (w == waits) begin
        data_ack = 1'b1;
        data_rd_data = rdata;
      end
      @(posedge clk); #1;
      data_ack = 1'b0;
    end
    chk("data_req_drop", 32'(data_req), 32'd0);
    chk("rdy_after_ack", 32'(pipe_in_rdy), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pipeEXWB_t b;
    rstz = 1'b0; execute = '0; pipe_in_vld = 1'b0; data_rd_data = '0; data_ack = 1'b0;
    #12;
    chk("rst_regwr_en", 32'(regwr_en), 32'd0);
    chk("rst_branch", 32'(branch), 32'd0);
    chk("rst_data_req", 32'(data_req), 32'd0);
    chk("rst_data_wr_en", 32'(data_wr_en), 32'd0);
    chk("rst_trap_vld", 32'(trap_vld), 32'd0);
    chk("rst_data_addr", data_addr, 32'd0);
    chk("rst_data_mask", 32'(data_mask), 32'd0);
    chk("rst_regwr_data", regwr_data, 32'd0);
    chk("rst_rdy", 32'(pipe_in_rdy), 32'd1);
    @(negedge clk); rstz = 1'b1;
    @(posedge clk); #1;

    // ALU ops back to back, second one targets x0
    sb.push_back(mk_exp(3'b100, 5'd5, 32'hDEADBEEF, '0, '0, '0));
    issue(mk_alu(5'd5, 32'hDEADBEEF));
    issue(mk_alu(5'd0, 32'hDEADBEEF));
    sb.push_back(mk_exp(3'b100, 5'd31, 32'h0000_0001, '0, '0, '0));
    issue(mk_alu(5'd31, 32'h0000_0001));

    // JAL: link write and redirect together
    b = mk_alu(5'd1, 32'h104); b.branch = 1'b1; b.result2 = 32'h200;
    sb.push_back(mk_exp(3'b110, 5'd1, 32'h104, 32'h200, '0, '0));
    issue(b);

    // Conditional branch not taken, then taken
    b = '0; b.branch_cond = 1'b1; b.result1 = 32'h0; b.result2 = 32'h300; b.rd = 5'd7;
    issue(b);
    b.result1 = 32'h1; b.result2 = 32'h340;
    sb.push_back(mk_exp(3'b010, '0, '0, 32'h340, '0, '0));
    issue(b);

    // Signed / unsigned byte load at 0x1003 with three wait cycles
    sb.push_back(mk_exp(3'b100, 5'd10, 32'hFFFFFF80, '0, '0, '0));
    mem_op(mk_mem(1'b1, BYTE, 1'b0, 5'd10, 32'h1003, '0), 3, 32'h80FFFFFF,
           32'h1000, 4'b1000, '0);
    sb.push_back(mk_exp(3'b100, 5'd11, 32'h00000080, '0, '0, '0));
    mem_op(mk_mem(1'b1, BYTE, 1'b1, 5'd11, 32'h1003, '0), 3, 32'h80FFFFFF,
           32'h1000, 4'b1000, '0);

    // Half store at 0x2002, ack on first request cycle
    mem_op(mk_mem(1'b0, HALF, 1'b0, 5'd0, 32'h2002, 32'h1234), 0, '0,
           32'h2000, 4'b1100, 32'h12340000);

    // Signed half load from upper lanes, unsigned half from lower lanes
    sb.push_back(mk_exp(3'b100, 5'd12, 32'hFFFF8001, '0, '0, '0));
    mem_op(mk_mem(1'b1, HALF, 1'b0, 5'd12, 32'h0000_0042, '0), 1, 32'h8001_1234,
           32'h40, 4'b1100, '0);
    sb.push_back(mk_exp(3'b100, 5'd13, 32'h0000F00D, '0, '0, '0));
    mem_op(mk_mem(1'b1, HALF, 1'b1, 5'd13, 32'h0000_0080, '0), 0, 32'h1234_F00D,
           32'h80, 4'b0011, '0);

    // Word store aligned; load to x0 writes nothing
    mem_op(mk_mem(1'b0, WORD, 1'b0, 5'd0, 32'h0000_0400, 32'hCAFEF00D), 2, '0,
           32'h400, 4'hF, 32'hCAFEF00D);
    mem_op(mk_mem(1'b1, WORD, 1'b0, 5'd0, 32'h0000_0404, '0), 0, 32'h1111_2222,
           32'h404, 4'hF, '0);

    // Misaligned word load at 0x3001
`ifdef KRONOS_MISALIGN_TRAP_EN
    sb.push_back(mk_exp(3'b001, '0, '0, '0, LD_MISALIGN, 32'h3001));
    issue(mk_mem(1'b1, WORD, 1'b0, 5'd14, 32'h3001, '0));
    chk("misalign_no_req", 32'(data_req), 32'd0);
    chk("misalign_rdy", 32'(pipe_in_rdy), 32'd1);
    sb.push_back(mk_exp(3'b001, '0, '0, '0, ST_MISALIGN, 32'h3003));
    issue(mk_mem(1'b0, HALF, 1'b0, 5'd0, 32'h3003, 32'h55));
    chk("misalign_st_no_req", 32'(data_req), 32'd0);
`else
    sb.push_back(mk_exp(3'b100, 5'd14, 32'h00AABBCC, '0, '0, '0));
    mem_op(mk_mem(1'b1, WORD, 1'b0, 5'd14, 32'h3001, '0), 0, 32'hAABBCCDD,
           32'h3000, 4'hF, '0);
`endif

    // Illegal instruction: trap with zero value, no write
    b = mk_alu(5'd9, 32'h1234_5678); b.is_illegal = 1'b1;
    sb.push_back(mk_exp(3'b001, '0, '0, '0, ILLEGAL, 32'h0));
    issue(b);

    // Ack while idle is ignored
    data_ack = 1'b1; data_rd_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    data_ack = 1'b0;
    chk("stray_ack_rdy", 32'(pipe_in_rdy), 32'd1);
    chk("stray_ack_req", 32'(data_req), 32'd0);

    // Reset while a store is in flight aborts it immediately
    issue(mk_mem(1'b0, WORD, 1'b0, 5'd0, 32'h0000_0500, 32'h1));
    chk("pre_rst_req", 32'(data_req), 32'd1);
    #2 rstz = 1'b0;
    #1;
    chk("midrst_data_req", 32'(data_req), 32'd0);
    chk("midrst_rdy", 32'(pipe_in_rdy), 32'd1);
    chk("midrst_wr_en", 32'(data_wr_en), 32'd0);
    @(negedge clk); rstz = 1'b1;
    @(posedge clk); #1;

    // Stage resumes normally after reset
    sb.push_back(mk_exp(3'b100, 5'd3, 32'h0BAD_F00D, '0, '0, '0));
    issue(mk_alu(5'd3, 32'h0BAD_F00D));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kronos_writeback.md
# kronos_writeback

Kronos RV32I write-back stage. It sits directly downstream of the execute stage and consumes its `pipeEXWB_t` bundle over a valid/ready handshake. It commits ALU results to the register file, resolves jumps and branches into a redirect pulse, and runs load/store transactions on the data bus with byte-lane alignment and sign extension. It also reports illegal-instruction and misalignment traps.

## Interface
Parameters:
- none; all widths are fixed by RV32I.

Ports:
- `clk`  in  1  clock
- `rstz`  in  1  reset, asynchronous, active-low
- `execute`  in  `pipeEXWB_t`  fields: `result1`, `result2`, `rd`, `rd_write`, `branch`, `branch_cond`, `ld`, `st`, `data_size`, `data_uns`, `is_illegal`
- `pipe_in_vld`  in  1  execute bundle valid
- `pipe_in_rdy`  out  1  stage can accept
- `regwr_data`  out  32  register-file write data
- `regwr_sel`  out  5  register-file write index
- `regwr_en`  out  1  one-cycle write strobe
- `branch`  out  1  one-cycle redirect pulse; upstream uses it as flush
- `branch_target`  out  32  redirect PC
- `data_addr`  out  32  word-aligned bus address
- `data_req`  out  1  bus request, held until ack
- `data_wr_en`  out  1  1 = store
- `data_mask`  out  4  byte-lane enables
- `data_wr_data`  out  32  lane-shifted store data
- `data_rd_data`  in  32  load data, valid with ack
- `data_ack`  in  1  bus completion
- `trap_vld`  out  1  one-cycle trap pulse
- `trap_cause`  out  4  mcause code
- `trap_value`  out  32  faulting address, or 0

## Operation
- Field semantics:
  - ALU op: `result1` is the rd value.
  - Jump (`branch=1`): `result1` is the link value, `result2` is the target.
  - Conditional branch (`branch_cond=1`): taken iff `result1[0]`; `result2` is the target; no rd write.
  - `ld`/`st`: `result1` is the byte address; `result2` is store data, unshifted.
- States:
  - STEADY: accepts input.
  - MEM: load/store in flight.
- Transitions:
  - STEADY to MEM on accept of `ld` or `st` (when no trap is raised).
  - MEM to STEADY on `data_ack`.
- `pipe_in_rdy` = (state == STEADY). It is combinational and is 1 during and after reset.
- Non-memory accept:
  - Next cycle, `regwr_en` = `rd_write` && (`rd` != 0), with `regwr_data`=`result1` and `regwr_sel`=`rd`.
  - Jump, or conditional branch taken: `branch`=1 next cycle, with `branch_target`=`result2`.
- Memory accept:
  - Next cycle, `data_req`=1 with `data_addr`={`result1[31:2]`,2'b00}.
  - `data_mask`: byte = 1<<a[1:0]; half = 3<<a[1:0]; word = 4'hF; bits shifted past lane 3 are dropped.
  - `data_wr_data` = `result2` << (8*a[1:0]).
  - All bus outputs are stable while `data_req` && !`data_ack`.
- On `data_ack` in MEM:
  - `data_req` drops the next cycle.
  - Load: rd data = `data_rd_data` >> (8*a[1:0]), truncated to size, then zero-extended if `data_uns` else sign-extended. It is written via `regwr_*` the next cycle, with `rd`=0 suppressed.
  - Store: no register write.
- `data_size` encoding: 0 byte, 1 half, 2 word; value 3 is treated as word.
- `is_illegal` on accept: `trap_vld`=1 next cycle, `trap_cause`=2, `trap_value`=0. No register write, branch or bus activity.
- Strobes `regwr_en`, `branch` and `trap_vld` are single-cycle. At most one of them fires per instruction, except that a jump fires `regwr_en` and `branch` together.
- Reset values:
  - `regwr_en`, `branch`, `data_req`, `data_wr_en`, `trap_vld` = 0.
  - All data, address and mask outputs = 0.
  - State = STEADY.
- Reset mid-MEM aborts the transaction immediately; `data_req` drops asynchronously.

## Timing
- ALU, branch and trap: accept at cycle N, effect at N+1. Throughput is 1 per cycle.
- Load or store with ack at the first request cycle: accept at N, `data_req` at N+1, ack at N+1, `regwr_en` (load) at N+2, next accept at N+2.
- Each wait cycle (no ack) adds one cycle. There is no timeout.
- `data_ack` outside MEM is ignored.
- `pipe_in_vld` while not ready: the bundle must be held by upstream; no acceptance occurs.

## Configuration
- `KRONOS_MISALIGN_TRAP_EN` defined:
  - Half access with a[0]=1, or word access with a[1:0]!=0, raises a trap on accept at N+1 and performs no bus request.
  - `trap_cause`=4 (load) or 6 (store); `trap_value`=`result1`.
- Undefined: no misalignment check; lanes are truncated per the mask rule above.

## Structure
- `kronos_types` gains:
  - data-size constants BYTE/HALF/WORD;
  - trap-cause constants (ILLEGAL=2, LD_MISALIGN=4, ST_MISALIGN=6);
  - the state enum `wb_state_e`.
- One combinational sub-module, `kronos_lsu_align`. It produces the store lane shift and mask, and the load extract with sign/zero extension.

## Test plan
- ALU op with `rd`=5, `result1`=0xDEADBEEF -> `regwr_en` for 1 cycle at N+1 with `regwr_sel`=5, `regwr_data`=0xDEADBEEF. The same op with `rd`=0 -> no write.
- JAL: `rd`=1, `result1`=0x104, `result2`=0x200 -> `regwr_en` with data 0x104, `branch`=1 and `branch_target`=0x200, all at N+1. Conditional branch with `result1[0]`=0 -> no pulse.
- Signed byte load at addr 0x1003, bus returns 0x80FFFFFF after 3 wait cycles -> `data_addr`=0x1000, `data_req` held for 4 cycles, `regwr_data`=0xFFFFFF80. The same load with `data_uns` -> 0x00000080.
- Half store of `result2`=0x1234 at 0x2002 -> `data_mask`=4'b1100, `data_wr_data`=0x12340000, `data_wr_en`=1. `pipe_in_rdy`=0 until ack.
- Word load at 0x3001: with `KRONOS_MISALIGN_TRAP_EN` -> `trap_vld`, `trap_cause`=4, `trap_value`=0x3001, no `data_req`. Without it -> `data_req` to 0x3000.
- `rstz` asserted while in MEM -> `data_req`=0 and `pipe_in_rdy`=1 immediately. `is_illegal` accept -> `trap_cause`=2, no write.
